// File: rtl/pipe_stage_skid.sv
// Width-configurable pipeline stage with valid/ready on both sides and a
// one-beat skid register, so in_ready comes only from registered state.
module pipe_stage_skid #(
   parameter int unsigned       DATA_W    = 160,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int unsigned       CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Encoding equals the number of held beats, so occupancy is the state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stateT;

   stateT             stateReg;
   stateT             stateNext;
   logic [DATA_W-1:0] mainData;
   logic [DATA_W-1:0] skidData;
   logic [CNT_W-1:0]  stallCnt;
   logic              mainValid;
   logic              skidValid;
   logic              inFire;
   logic              outFire;
   logic              loadMainIn;
   logic              loadMainSkid;
   logic              loadSkid;

   assign mainValid = (stateReg != EMPTY);
   assign skidValid = (stateReg == TWO);
   assign in_ready  = rst & ~skidValid;
   assign inFire    = in_valid & in_ready;
   assign outFire   = mainValid & out_ready;

   assign out_valid = mainValid;
   assign out_data  = mainData;
   assign occupancy = stateReg;
   assign stall_cnt = stallCnt;

   always_comb begin
      stateNext    = stateReg;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      case (stateReg)
         EMPTY: begin
            if (inFire) begin
               stateNext  = ONE;
               loadMainIn = 1'b1;
            end
         end
         ONE: begin
            if (inFire && outFire) begin
               loadMainIn = 1'b1;
            end else if (inFire) begin
               stateNext = TWO;
               loadSkid  = 1'b1;
            end else if (outFire) begin
               stateNext = EMPTY;
            end
         end
         TWO: begin
            if (outFire) begin
               stateNext    = ONE;
               loadMainSkid = 1'b1;
            end
         end
         default: stateNext = EMPTY;
      endcase
      // Flush drops everything held plus any beat offered this cycle.
      if (flush) begin
         stateNext    = EMPTY;
         loadMainIn   = 1'b0;
         loadMainSkid = 1'b0;
         loadSkid     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateReg <= EMPTY;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mainData <= RESET_VAL;
         skidData <= '0;
      end else begin
         if (loadMainIn) begin
            mainData <= in_data;
         end else if (loadMainSkid) begin
            mainData <= skidData;
         end
         if (loadSkid) begin
            skidData <= in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCnt <= '0;
      end else if (mainValid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

endmodule
